// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the SSP slave front end: the UART register map
// addresses carried in the frame header, the frame geometry and the
// frame-tracking state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package ssp_pkg;

  // UART register addresses carried in frame bits 15..13
  localparam logic [2:0] RA_UCR = 3'd0;
  localparam logic [2:0] RA_USR = 3'd1;
  localparam logic [2:0] RA_TDR = 3'd2;
  localparam logic [2:0] RA_RDR = 3'd3;
  localparam logic [2:0] RA_SPR = 3'd4;

  // Frame geometry: 4 header bits (RA + WnR) followed by 12 data bits
  localparam int FRAME_W = 16;
  localparam int HDR_W   = 4;
  localparam int DATA_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } ssp_state_t;

endpackage

// File: rtl/ssp_sync.sv
// ---------------------------------------------------------------------------
// ssp_sync
// Brings one asynchronous pin into the clk domain through two flops and
// produces single-cycle rise/fall strobes from the synchronized level.
// Ports:
//   clk   in  : system clock, rising edge
//   rst   in  : synchronous active-high reset, clears the whole pipeline
//   din   in  : asynchronous input pin
//   level out : synchronized level
//   rise  out : 1-cycle strobe, synchronized level went 0->1
//   fall  out : 1-cycle strobe, synchronized level went 1->0
// ---------------------------------------------------------------------------
module ssp_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Two flops for metastability, a third holds the previous synchronized
  // value so the edge strobes compare two clean samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/ssp_slave_fe.sv
// ---------------------------------------------------------------------------
// ssp_slave_fe
// SPI (mode 0) slave front end that turns 16-bit frames into UART register
// accesses. Header (RA, WnR) is presented as soon as it has been shifted in,
// read data is shifted out on MISO during the 12 data bits, and the write
// data is presented with a one-cycle end-of-cycle strobe.
// Ports:
//   Clk       in      : system clock, rising edge
//   Rst       in      : synchronous active-high reset
//   SSP_SSEL  in      : frame select, active high, asynchronous
//   SSP_SCK   in      : serial clock, idle low, asynchronous
//   SSP_MOSI  in      : serial data in, MSB first
//   SSP_MISO  out     : serial data out, MSB first
//   SSP_RA    out [3] : register address from the frame header
//   SSP_WnR   out     : 1 = write, 0 = read
//   SSP_En    out     : register access in progress
//   SSP_EOC   out     : end-of-cycle strobe, 1 Clk
//   SSP_DI    out [12]: write data (frame bits 11..0)
//   SSP_DO    in  [12]: read data from the UART
//   FrmErr    out     : aborted-frame strobe, 1 Clk
// ---------------------------------------------------------------------------
module ssp_slave_fe
  import ssp_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                SSP_SSEL,
  input  logic                SSP_SCK,
  input  logic                SSP_MOSI,
  output logic                SSP_MISO,
  output logic [2:0]          SSP_RA,
  output logic                SSP_WnR,
  output logic                SSP_En,
  output logic                SSP_EOC,
  output logic [DATA_W-1:0]   SSP_DI,
  input  logic [DATA_W-1:0]   SSP_DO,
  output logic                FrmErr
);

  localparam logic [4:0] HDR_LAST   = 5'(HDR_W - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_W - 1);

  logic ssel_rise;
  logic ssel_fall;
  logic sck_rise;
  logic sck_fall;
  logic mosi;

  logic unused_ssel_level;
  logic unused_sck_level;
  logic unused_mosi_rise;
  logic unused_mosi_fall;
  logic unused_frame_msb;

  ssp_state_t          state;
  logic [4:0]          bit_cnt;
  logic [FRAME_W-1:0]  shift_reg;
  logic [DATA_W-1:0]   miso_reg;
  logic                hdr_done;
  logic                load_pending;
  logic                done_pending;

  ssp_sync u_sync_ssel (
    .clk   (Clk),
    .rst   (Rst),
    .din   (SSP_SSEL),
    .level (unused_ssel_level),
    .rise  (ssel_rise),
    .fall  (ssel_fall)
  );

  ssp_sync u_sync_sck (
    .clk   (Clk),
    .rst   (Rst),
    .din   (SSP_SCK),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // MOSI only needs its level; it is sampled on the SCK rise strobe, which
  // has the same two-flop latency so data and clock stay aligned.
  ssp_sync u_sync_mosi (
    .clk   (Clk),
    .rst   (Rst),
    .din   (SSP_MOSI),
    .level (mosi),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  // The top frame bit has already been copied to SSP_RA at header time.
  assign unused_frame_msb = shift_reg[FRAME_W-1];

  // Frame tracker. The *_pending flags split each phase into a chain of
  // one-cycle steps: header latch -> MISO load, and frame end -> EOC.
  // En stays high through the EOC cycle and drops on the following edge.
  // An SSEL drop that coincides with the last SCK rise still completes the
  // frame; any other SSEL drop in HDR/DATA aborts with FrmErr.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      miso_reg     <= '0;
      hdr_done     <= 1'b0;
      load_pending <= 1'b0;
      done_pending <= 1'b0;
      SSP_MISO     <= 1'b0;
      SSP_RA       <= '0;
      SSP_WnR      <= 1'b0;
      SSP_En       <= 1'b0;
      SSP_EOC      <= 1'b0;
      SSP_DI       <= '0;
      FrmErr       <= 1'b0;
    end else begin
      SSP_EOC      <= 1'b0;
      FrmErr       <= 1'b0;
      hdr_done     <= 1'b0;
      load_pending <= 1'b0;
      done_pending <= 1'b0;

      if (hdr_done) begin
        SSP_RA       <= shift_reg[3:1];
        SSP_WnR      <= shift_reg[0];
        SSP_En       <= 1'b1;
        load_pending <= 1'b1;
      end

      if (load_pending) begin
        miso_reg <= SSP_DO;
      end

      if (done_pending) begin
        SSP_DI  <= shift_reg[DATA_W-1:0];
        SSP_EOC <= 1'b1;
      end

      if (SSP_EOC) begin
        SSP_En <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ssel_rise) begin
            state     <= HDR;
            bit_cnt   <= '0;
            shift_reg <= '0;
            miso_reg  <= '0;
            SSP_MISO  <= 1'b0;
          end
        end

        HDR: begin
          if (ssel_fall) begin
            state        <= IDLE;
            SSP_En       <= 1'b0;
            FrmErr       <= 1'b1;
            hdr_done     <= 1'b0;
            load_pending <= 1'b0;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], mosi};
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == HDR_LAST) begin
              state    <= DATA;
              hdr_done <= 1'b1;
            end
          end
        end

        DATA: begin
          if (sck_rise && (bit_cnt == FRAME_LAST)) begin
            shift_reg    <= {shift_reg[FRAME_W-2:0], mosi};
            bit_cnt      <= bit_cnt + 5'd1;
            done_pending <= 1'b1;
            state        <= ssel_fall ? IDLE : DONE;
          end else if (ssel_fall) begin
            state        <= IDLE;
            SSP_En       <= 1'b0;
            FrmErr       <= 1'b1;
            hdr_done     <= 1'b0;
            load_pending <= 1'b0;
          end else begin
            if (sck_rise) begin
              shift_reg <= {shift_reg[FRAME_W-2:0], mosi};
              bit_cnt   <= bit_cnt + 5'd1;
            end
            // Every SCK fall seen in DATA (after rises 4..15) presents the
            // next read bit, ready for the master's following rise.
            if (sck_fall) begin
              SSP_MISO <= miso_reg[DATA_W-1];
              miso_reg <= {miso_reg[DATA_W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (ssel_fall) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssp_slave_fe.sv
// ---------------------------------------------------------------------------
// tb_ssp_slave_fe
// Directed bench for the SSP slave front end. Each SCK phase is 4 Clk,
// comfortably above the 3-Clk minimum. A negedge monitor counts EOC and
// FrmErr strobes and records what the UART side saw at each EOC.
// ---------------------------------------------------------------------------
module tb_ssp_slave_fe;
  import ssp_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        SSP_SSEL;
  logic        SSP_SCK;
  logic        SSP_MOSI;
  logic        SSP_MISO;
  logic [2:0]  SSP_RA;
  logic        SSP_WnR;
  logic        SSP_En;
  logic        SSP_EOC;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO;
  logic        FrmErr;

  int checks = 0;
  int errors = 0;

  int          eoc_count = 0;
  int          frm_count = 0;
  logic [11:0] last_di = '0;
  logic [2:0]  last_ra = '0;
  logic        en_at_eoc = 1'b0;
  logic        en_after_eoc = 1'b1;
  logic        en_at_frmerr = 1'b1;
  logic        prev_eoc = 1'b0;
  logic [11:0] miso_cap = '0;
  logic [3:0]  hdr_miso = '0;

  int base_eoc;
  int base_frm;

  ssp_slave_fe dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SSP_SSEL (SSP_SSEL),
    .SSP_SCK  (SSP_SCK),
    .SSP_MOSI (SSP_MOSI),
    .SSP_MISO (SSP_MISO),
    .SSP_RA   (SSP_RA),
    .SSP_WnR  (SSP_WnR),
    .SSP_En   (SSP_En),
    .SSP_EOC  (SSP_EOC),
    .SSP_DI   (SSP_DI),
    .SSP_DO   (SSP_DO),
    .FrmErr   (FrmErr)
  );

  always #5 Clk = ~Clk;

  // Strobe monitor, sampled on the falling edge away from register updates
  always @(negedge Clk) begin
    if (prev_eoc) en_after_eoc = SSP_En;
    prev_eoc = SSP_EOC;
    if (SSP_EOC) begin
      eoc_count = eoc_count + 1;
      last_di   = SSP_DI;
      last_ra   = SSP_RA;
      en_at_eoc = SSP_En;
    end
    if (FrmErr) begin
      frm_count    = frm_count + 1;
      en_at_frmerr = SSP_En;
    end
  end

  // Safety net: the stimulus uses only fixed delays, this catches anything else
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Clocks out bits [first, last) of word, MSB first; bits past 15 are 1.
  // MISO is sampled just before each rise, as the master would.
  task automatic apply_stimulus(input logic [15:0] word, input int first,
                                input int last);
    logic b;
    logic seen;
    for (int i = first; i < last; i++) begin
      b = (i < 16) ? word[4'(15 - i)] : 1'b1;
      SSP_MOSI = b;
      repeat (4) @(negedge Clk);
      seen = SSP_MISO;
      if (i < 4) hdr_miso[2'(3 - i)] = seen;
      else if (i < 16) miso_cap[4'(15 - i)] = seen;
      SSP_SCK = 1'b1;
      repeat (4) @(negedge Clk);
      SSP_SCK = 1'b0;
    end
  endtask

  task automatic start_frame();
    SSP_SSEL = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic end_frame();
    SSP_SSEL = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  initial begin
    Rst      = 1'b1;
    SSP_SSEL = 1'b0;
    SSP_SCK  = 1'b0;
    SSP_MOSI = 1'b0;
    SSP_DO   = 12'h000;
    repeat (3) @(negedge Clk);

    // Reset state
    check_output("reset_ra",   16'(SSP_RA),   16'h0);
    check_output("reset_wnr",  16'(SSP_WnR),  16'h0);
    check_output("reset_en",   16'(SSP_En),   16'h0);
    check_output("reset_eoc",  16'(SSP_EOC),  16'h0);
    check_output("reset_frm",  16'(FrmErr),   16'h0);
    check_output("reset_di",   16'(SSP_DI),   16'h0);
    check_output("reset_miso", 16'(SSP_MISO), 16'h0);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);

    // Write TDR 0x5A5: header 010_1
    $display("[TB] write TDR");
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h55A5, 0, 4);
    check_output("wr_hdr_ra",  16'(SSP_RA),  16'h2);
    check_output("wr_hdr_wnr", 16'(SSP_WnR), 16'h1);
    check_output("wr_hdr_en",  16'(SSP_En),  16'h1);
    apply_stimulus(16'h55A5, 4, 16);
    repeat (4) @(negedge Clk);
    check_output("wr_eoc_cnt",   16'(eoc_count - base_eoc), 16'h1);
    check_output("wr_eoc_di",    16'(last_di),              16'h5A5);
    check_output("wr_eoc_ra",    16'(last_ra),              16'h2);
    check_output("wr_en_at_eoc", 16'(en_at_eoc),            16'h1);
    check_output("wr_en_after",  16'(en_after_eoc),         16'h0);
    check_output("wr_frmerr",    16'(frm_count - base_frm), 16'h0);
    end_frame();
    check_output("wr_di_hold",   16'(SSP_DI), 16'h5A5);

    // Read USR with DO = 0xC31: header 001_0, trailing data 0x3C7
    $display("[TB] read USR");
    SSP_DO   = 12'hC31;
    base_eoc = eoc_count;
    start_frame();
    apply_stimulus(16'h23C7, 0, 16);
    repeat (4) @(negedge Clk);
    check_output("rd_hdr_miso", 16'(hdr_miso),             16'h0);
    check_output("rd_miso",     16'(miso_cap),             16'hC31);
    check_output("rd_eoc_cnt",  16'(eoc_count - base_eoc), 16'h1);
    check_output("rd_di",       16'(last_di),              16'h3C7);
    check_output("rd_ra",       16'(SSP_RA),               16'h1);
    check_output("rd_wnr",      16'(SSP_WnR),              16'h0);
    end_frame();

    // Abort after 9 rises
    $display("[TB] abort");
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h6ABC, 0, 9);
    check_output("ab_en_before", 16'(SSP_En), 16'h1);
    end_frame();
    check_output("ab_frm_cnt",   16'(frm_count - base_frm), 16'h1);
    check_output("ab_en_at_frm", 16'(en_at_frmerr),         16'h0);
    check_output("ab_en",        16'(SSP_En),               16'h0);
    check_output("ab_eoc_cnt",   16'(eoc_count - base_eoc), 16'h0);
    check_output("ab_state",     16'(dut.state),            16'(IDLE));
    check_output("ab_di_hold",   16'(SSP_DI),               16'h3C7);

    // Overrun: 20 rises, extra bits are all 1
    $display("[TB] overrun");
    SSP_DO   = 12'h000;
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h5ABC, 0, 20);
    repeat (4) @(negedge Clk);
    check_output("ov_eoc_cnt", 16'(eoc_count - base_eoc), 16'h1);
    check_output("ov_di",      16'(last_di),              16'hABC);
    check_output("ov_frm",     16'(frm_count - base_frm), 16'h0);
    end_frame();

    // Reset at bit 7, then a clean SPR write of 0x0FF
    $display("[TB] reset mid-frame");
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h80FF, 0, 7);
    Rst      = 1'b1;
    SSP_SSEL = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    check_output("rs_eoc_cnt", 16'(eoc_count - base_eoc), 16'h0);
    check_output("rs_frm",     16'(frm_count - base_frm), 16'h0);
    check_output("rs_ra",      16'(SSP_RA),               16'h0);
    check_output("rs_en",      16'(SSP_En),               16'h0);
    start_frame();
    apply_stimulus(16'h80FF, 0, 16);
    repeat (4) @(negedge Clk);
    end_frame();
    check_output("rs_eoc_cnt2", 16'(eoc_count - base_eoc), 16'h1);
    check_output("rs_ra2",      16'(last_ra),              16'h4);
    check_output("rs_di2",      16'(last_di),              16'h0FF);
    check_output("rs_frm2",     16'(frm_count - base_frm), 16'h0);

    // SSEL drop in the same cycle as the 16th rise completes the frame
    $display("[TB] simultaneous end");
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h17E1, 0, 15);
    SSP_MOSI = 1'b1;
    repeat (4) @(negedge Clk);
    SSP_SCK  = 1'b1;
    SSP_SSEL = 1'b0;
    repeat (4) @(negedge Clk);
    SSP_SCK = 1'b0;
    repeat (4) @(negedge Clk);
    check_output("sim_eoc_cnt", 16'(eoc_count - base_eoc), 16'h1);
    check_output("sim_di",      16'(last_di),              16'h7E1);
    check_output("sim_frm",     16'(frm_count - base_frm), 16'h0);
    check_output("sim_state",   16'(dut.state),            16'(IDLE));

    // Back-to-back: UCR write 0x001, SSEL low 4 Clk, RDR read
    $display("[TB] back-to-back");
    base_eoc = eoc_count;
    base_frm = frm_count;
    start_frame();
    apply_stimulus(16'h1001, 0, 16);
    repeat (4) @(negedge Clk);
    check_output("bb_ra_first", 16'(last_ra), 16'(RA_UCR));
    check_output("bb_di_first", 16'(last_di), 16'h001);
    SSP_SSEL = 1'b0;
    repeat (4) @(negedge Clk);
    start_frame();
    apply_stimulus(16'h6123, 0, 16);
    repeat (4) @(negedge Clk);
    end_frame();
    check_output("bb_eoc_cnt",   16'(eoc_count - base_eoc), 16'h2);
    check_output("bb_ra_second", 16'(last_ra),              16'(RA_RDR));
    check_output("bb_frm",       16'(frm_count - base_frm), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
